// File: rtl/shift_sub_divider_8_bits_if.sv
// ---------------------------------------------------------------------------
// shift_sub_divider_8_bits_if
//
// This interface bundles the request and result signals of the 8-bit
// shift-subtract divider. Clock and reset are not part of the bundle.
//
//   start        request, sampled only while the divider is idle
//   dividend     unsigned dividend, sampled on the accept edge
//   divisor      unsigned divisor, sampled on the accept edge
//   quotient     registered quotient, updated only on completion
//   remainder    registered remainder, updated only on completion
//   busy         high from the accept edge until the return to idle
//   done         one-cycle completion pulse
//   div_by_zero  set when the last completed operation had divisor == 0
//
// Modports:
//   master  the requester, which drives the operands and reads the results
//   slave   the divider itself
// ---------------------------------------------------------------------------
interface shift_sub_divider_8_bits_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface : shift_sub_divider_8_bits_if

// File: rtl/shift_sub_divider_8_bits.sv
// ---------------------------------------------------------------------------
// shift_sub_divider_8_bits
//
// This is a sequential 8-bit unsigned restoring divider. It produces one
// quotient bit per clock. A request is accepted in IDLE when start is high.
// A normal divide spends 8 cycles in RUN and 1 cycle in DONE, so done
// asserts 8 cycles after the accept edge. A zero divisor bypasses RUN and
// registers quotient = 8'hFF and remainder = dividend on the accept edge.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; it aborts any operation in flight
//   bus    shift_sub_divider_8_bits_if.slave
//          (start, dividend, divisor -> quotient, remainder, busy, done,
//           div_by_zero)
// ---------------------------------------------------------------------------
module shift_sub_divider_8_bits (
    input  logic                            clk,
    input  logic                            rst_n,
    shift_sub_divider_8_bits_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [8:0] r_rem;        // partial remainder
    logic [7:0] r_q;          // dividend shifting out, quotient shifting in
    logic [7:0] r_d;          // captured divisor
    logic [2:0] r_cnt;        // iteration index 0..7

    logic [7:0] r_quotient;
    logic [7:0] r_remainder;
    logic       r_div_by_zero;

    logic       w_accept;
    logic       w_div_zero;
    logic       w_last_iter;

    logic [8:0] w_trial;
    logic [8:0] w_diff;
    logic       w_fits;
    logic [8:0] w_rem_next;
    logic [7:0] w_q_next;

    // -----------------------------------------------------------------------
    // One restoring iteration. The next dividend bit shifts into the
    // partial remainder. The divisor is subtracted only when it fits. The
    // compare is 9 bits wide because the shifted value can reach 2*D-1,
    // which overflows 8 bits when D > 128.
    // -----------------------------------------------------------------------
    assign w_trial    = {r_rem[7:0], r_q[7]};
    assign w_fits     = (w_trial >= {1'b0, r_d});
    assign w_diff     = w_trial - {1'b0, r_d};
    assign w_rem_next = w_fits ? w_diff : w_trial;
    assign w_q_next   = {r_q[6:0], w_fits};

    assign w_div_zero  = (bus.divisor == 8'd0);
    assign w_last_iter = (r_cnt == 3'd7);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal this block drives gets a default first. If any path
    // leaves one unassigned, synthesis infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_iter) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then sees the pre-edge values of the others, whatever order
    // the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Working registers: load on accept, iterate while in RUN
    // -----------------------------------------------------------------------
    // NOTE: these are a handful of flops and not a memory array, so they all
    // take the asynchronous reset. The reset state is then fully defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 9'd0;
            r_q   <= 8'd0;
            r_d   <= 8'd0;
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_rem <= 9'd0;
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_cnt <= 3'd0;
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers. They change only when an operation completes, and
    // they hold their value through IDLE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= 8'd0;
            r_remainder   <= 8'd0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept && w_div_zero) begin
            r_quotient    <= 8'hFF;
            r_remainder   <= bus.dividend;
            r_div_by_zero <= 1'b1;
        end else if ((r_state == RUN) && w_last_iter) begin
            // Use the values of the 8th iteration, which complete on this
            // same edge.
            r_quotient    <= w_q_next;
            r_remainder   <= w_rem_next[7:0];
            r_div_by_zero <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. busy and done decode directly from the state register, so
    // reset clears them at the same moment it clears the state.
    // -----------------------------------------------------------------------
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);

endmodule : shift_sub_divider_8_bits

// File: tb/tb_shift_sub_divider_8_bits.sv
// ---------------------------------------------------------------------------
// tb_shift_sub_divider_8_bits
//
// This bench tests the 8-bit shift-subtract divider. Each request pushes
// its expected result, computed with plain / and %, into a queue. A
// separate monitor pops one entry on every done pulse and compares it.
// The stimulus side checks latency, busy timing, start-ignore behaviour
// and reset abort.
// ---------------------------------------------------------------------------
module tb_shift_sub_divider_8_bits;

    logic clk;
    logic rst_n;

    shift_sub_divider_8_bits_if bus ();

    shift_sub_divider_8_bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] quotient;
        logic [7:0] remainder;
        logic       dbz;
        logic [7:0] divisor;
    } exp_t;

    exp_t exp_q[$];

    int total  = 0;
    int bad    = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: unsigned division by definition, with the
    // divide-by-zero convention.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.divisor = b;
        if (b == 8'd0) begin
            e.quotient  = 8'hFF;
            e.remainder = a;
            e.dbz       = 1'b1;
        end else begin
            e.quotient  = a / b;
            e.remainder = a % b;
            e.dbz       = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compares the results on each done pulse, away from the edge.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient",    32'(bus.quotient),    32'(e.quotient));
                check("remainder",   32'(bus.remainder),   32'(e.remainder));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                if (e.divisor != 8'd0)
                    check("rem_lt_div", 32'(bus.remainder < e.divisor), 32'(1));
            end
        end
    end

    // Wait (bounded) until the divider is idle, sampling #1 after an edge.
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(1), 32'(0));
    endtask

    // Drive one request. On return the time is #1 after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        wait_idle();
        exp_q.push_back(model(a, b));
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 8'($urandom_range(0, 255));
        check("busy_after_accept", 32'(bus.busy), 32'(1));
    endtask

    // Count edges until done is seen and compare with the expected latency.
    // Then confirm that one edge later the block is idle with done low.
    task automatic wait_done(input int exp_lat, input string name);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n), 32'(exp_lat));
        @(posedge clk); #1;
        check("busy_low_after_done", 32'(bus.busy), 32'(0));
        check("done_one_cycle",      32'(bus.done), 32'(0));
    endtask

    initial begin
        int k;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        #1;
        check("rst_quotient",  32'(bus.quotient),    32'(0));
        check("rst_remainder", 32'(bus.remainder),   32'(0));
        check("rst_busy",      32'(bus.busy),        32'(0));
        check("rst_done",      32'(bus.done),        32'(0));
        check("rst_dbz",       32'(bus.div_by_zero), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 200 / 7 = 28 r 4
        start_op(8'd200, 8'd7);
        wait_done(8, "lat_200_7");

        // 255/1 then 0/13 with start held high; the second accept lands at E10
        wait_idle();
        exp_q.push_back(model(8'd255, 8'd1));
        exp_q.push_back(model(8'd0, 8'd13));
        bus.start    = 1'b1;
        bus.dividend = 8'd255;
        bus.divisor  = 8'd1;
        @(posedge clk); #1;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd13;
        wait_done(8, "lat_255_1");
        @(posedge clk); #1;
        check("held_start_reaccept", 32'(bus.busy), 32'(1));
        bus.start = 1'b0;
        wait_done(8, "lat_0_13");

        // 5/9 and 255/255
        start_op(8'd5, 8'd9);
        wait_done(8, "lat_5_9");
        start_op(8'd255, 8'd255);
        wait_done(8, "lat_255_255");

        // 77/0, then 10/3 clears div_by_zero
        start_op(8'd77, 8'd0);
        wait_done(0, "lat_77_0");
        start_op(8'd10, 8'd3);
        wait_done(8, "lat_10_3");

        // 100/10 with a start pulse at E3 that must be ignored
        k = n_done;
        start_op(8'd100, 8'd10);
        repeat (2) begin @(posedge clk); #1; end
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(5, "lat_100_10");
        repeat (5) begin @(posedge clk); #1; end
        check("single_done_pulse", 32'(n_done - k), 32'(1));
        check("hold_quotient",     32'(bus.quotient),  32'(10));
        check("hold_remainder",    32'(bus.remainder), 32'(0));
        check("busy_still_idle",   32'(bus.busy),      32'(0));

        // Reset at E4 of 200/7 aborts the divide with no done pulse
        start_op(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_quotient",  32'(bus.quotient),    32'(0));
        check("abort_remainder", 32'(bus.remainder),   32'(0));
        check("abort_busy",      32'(bus.busy),        32'(0));
        check("abort_done",      32'(bus.done),        32'(0));
        check("abort_dbz",       32'(bus.div_by_zero), 32'(0));
        void'(exp_q.pop_back());
        k = n_done;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_done_on_abort", 32'(n_done), 32'(k));
        start_op(8'd9, 8'd2);
        wait_done(8, "lat_9_2");

        // Random operands, with a zero divisor roughly one time in four
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start_op(a, b);
            wait_done((b == 8'd0) ? 0 : 8, "lat_random");
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sub_divider_8_bits
